// File: rtl/stoch_nn_pkg.sv
// Shared definitions for the stochastic neural-network blocks.
//   state_t      : decoder FSM states (IDLE, ACCUM)
//   stoch_cw     : per-lane signed count width able to hold -window..+window
//   stoch_delta  : signed contribution of one positive/negative rail bit pair
package stoch_nn_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Two extra bits over $clog2: one for the +window endpoint, one for sign.
  function automatic int stoch_cw(input int window);
    return $clog2(window) + 2;
  endfunction

  // p only -> +1, m only -> -1, equal rails cancel to 0.
  function automatic logic signed [1:0] stoch_delta(input logic p, input logic m);
    logic signed [1:0] d;
    d = 2'sd0;
    if (p && !m) begin
      d = 2'sd1;
    end else if (m && !p) begin
      d = -2'sd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/stoch_signed_updown.sv
// Signed up/down counter for one stochastic lane.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : count this cycle's rail pair
//   clear    : final sample of the window; counter restarts from 0
//   p, m     : positive / negative rail bits
//   fin      : running count including this cycle's delta (the window
//              result when sampled together with clear)
module stoch_signed_updown
  import stoch_nn_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 p,
  input  logic                 m,
  output logic signed [CW-1:0] fin
);

  logic signed [1:0]    delta;
  logic signed [CW-1:0] delta_ext;
  logic signed [CW-1:0] cnt;

  assign delta     = stoch_delta(p, m);
  assign delta_ext = {{(CW-2){delta[1]}}, delta};
  assign fin       = cnt + delta_ext;

  // Accumulate only qualified samples; on the last sample the parent captures
  // fin, so the counter restarts cleanly for the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= clear ? '0 : fin;
    end
  end

endmodule

// File: rtl/stoch_signed_decoder.sv
// Converts LANES signed stochastic bitstream pairs into two's-complement
// counts integrated over WINDOW enabled samples.
// Ports:
//   CLK, RST : clock and synchronous active-high reset
//   start    : begin a conversion window (ignored while busy)
//   en       : x_p/x_m sample valid this cycle
//   x_p, x_m : positive / negative rail bits, lane i = bit i
//   y        : lane i count at y[i*CW +: CW], signed
//   y_valid  : one-cycle pulse when y has been updated
//   busy     : window in progress
// Build option: define STOCH_DECODER_CONTINUOUS_EN to run windows
// back-to-back after the first start instead of one-shot.
module stoch_signed_decoder
  import stoch_nn_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int WINDOW = 256
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               start,
  input  logic                               en,
  input  logic [LANES-1:0]                   x_p,
  input  logic [LANES-1:0]                   x_m,
  output logic [LANES*stoch_cw(WINDOW)-1:0]  y,
  output logic                               y_valid,
  output logic                               busy
);

  localparam int CW = stoch_cw(WINDOW);

  state_t                 state;
  logic [CW-1:0]          scnt;
  logic                   sample;
  logic                   last;
  logic [LANES*CW-1:0]    fin_flat;

  // The start-cycle sample is never counted because state is still IDLE then.
  assign sample = (state == ACCUM) && en;
  assign last   = sample && (scnt == CW'(WINDOW - 1));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    stoch_signed_updown #(.CW(CW)) u_lane (
      .clk   (CLK),
      .rst   (RST),
      .en    (sample),
      .clear (last),
      .p     (x_p[i]),
      .m     (x_m[i]),
      .fin   (fin_flat[i*CW +: CW])
    );
  end

  // FSM, shared sample counter and result registers. y is captured from the
  // lanes' fin so the final sample of the window is included.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      scnt    <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (last) begin
            scnt    <= '0;
            y       <= fin_flat;
            y_valid <= 1'b1;
`ifndef STOCH_DECODER_CONTINUOUS_EN
            state   <= IDLE;
            busy    <= 1'b0;
`endif
          end else if (sample) begin
            scnt <= scnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Directed self-checking bench for stoch_signed_decoder with LANES=4, WINDOW=16.
module tb_stoch_signed_decoder;

  localparam int LANES  = 4;
  localparam int WINDOW = 16;
  localparam int CW     = 6;

  logic                CLK;
  logic                RST;
  logic                start;
  logic                en;
  logic [LANES-1:0]    x_p;
  logic [LANES-1:0]    x_m;
  logic [LANES*CW-1:0] y;
  logic                y_valid;
  logic                busy;

  int compared;
  int mismatched;

  stoch_signed_decoder #(.LANES(LANES), .WINDOW(WINDOW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .en      (en),
    .x_p     (x_p),
    .x_m     (x_m),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pack four signed lane counts into the y layout.
  function automatic logic [LANES*CW-1:0] pack4(input int l0, input int l1,
                                                input int l2, input int l3);
    logic [LANES*CW-1:0] r;
    r[0*CW +: CW] = CW'(l0);
    r[1*CW +: CW] = CW'(l1);
    r[2*CW +: CW] = CW'(l2);
    r[3*CW +: CW] = CW'(l3);
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge pass, and settle 1 time unit after it.
  task automatic applyStimulus(input logic s, input logic e,
                               input logic [LANES-1:0] p, input logic [LANES-1:0] m);
    start = s;
    en    = e;
    x_p   = p;
    x_m   = m;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyReset(input int n);
    RST   = 1'b1;
    start = 1'b0;
    en    = 1'b0;
    x_p   = '0;
    x_m   = '0;
    repeat (n) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] pp;
    logic [3:0] pm;
    compared   = 0;
    mismatched = 0;
    RST   = 1'b0;
    start = 1'b0;
    en    = 1'b0;
    x_p   = '0;
    x_m   = '0;

    // Reset state
    applyReset(2);
    checkOutput("reset_y", 32'(y), 32'(0));
    checkOutput("reset_valid", 32'(y_valid), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));

`ifdef STOCH_DECODER_CONTINUOUS_EN
    // Back-to-back windows: lane0 +1 every cycle, start pulse mid-run is ignored.
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000);
    checkOutput("cont_busy_start", 32'(busy), 32'(1));
    for (int k = 0; k < 3 * WINDOW; k++) begin
      applyStimulus((k == 20), 1'b1, 4'b0001, 4'b0000);
      checkOutput("cont_valid", 32'(y_valid), 32'((k % WINDOW) == WINDOW - 1));
      checkOutput("cont_busy", 32'(busy), 32'(1));
      if ((k % WINDOW) == WINDOW - 1) begin
        checkOutput("cont_y", 32'(y), 32'(pack4(16, 0, 0, 0)));
      end
    end
`else
    // en and rail activity while IDLE must not count
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
    end
    checkOutput("idle_y", 32'(y), 32'(0));
    checkOutput("idle_valid", 32'(y_valid), 32'(0));
    checkOutput("idle_busy", 32'(busy), 32'(0));

    // Basic window: lane0 +1, lane1 -1, lane2 both, lane3 none
    applyStimulus(1'b1, 1'b1, 4'b0101, 4'b0110);
    checkOutput("basic_busy_start", 32'(busy), 32'(1));
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0101, 4'b0110);
      if (k == WINDOW - 2) begin
        checkOutput("basic_early_valid", 32'(y_valid), 32'(0));
        checkOutput("basic_early_busy", 32'(busy), 32'(1));
      end
    end
    checkOutput("basic_y", 32'(y), 32'(pack4(16, -16, 0, 0)));
    checkOutput("basic_valid", 32'(y_valid), 32'(1));
    checkOutput("basic_busy_end", 32'(busy), 32'(0));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    checkOutput("basic_pulse_len", 32'(y_valid), 32'(0));
    checkOutput("basic_y_hold", 32'(y), 32'(pack4(16, -16, 0, 0)));

    // Patterned lane0: p=1100, m=0101 -> +1,0,0,-1 per period -> 0
    pp = 4'b1100;
    pm = 4'b0101;
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1'b0, 1'b1, {3'b000, pp[3 - (k % 4)]}, {3'b000, pm[3 - (k % 4)]});
    end
    checkOutput("pat1100_valid", 32'(y_valid), 32'(1));
    checkOutput("pat1100_y", 32'(y), 32'(pack4(0, 0, 0, 0)));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);

    // p=1110, m=0101 -> +1,0,+1,-1 per period -> +1 x 4 periods = +4
    pp = 4'b1110;
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1'b0, 1'b1, {3'b000, pp[3 - (k % 4)]}, {3'b000, pm[3 - (k % 4)]});
    end
    checkOutput("pat1110_valid", 32'(y_valid), 32'(1));
    checkOutput("pat1110_y", 32'(y), 32'(pack4(4, 0, 0, 0)));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);

    // en toggling: disabled cycles carry lane0 -1 and lane1 +1, which must be ignored
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 2 * WINDOW - 1; k++) begin
      if ((k % 2) == 0) begin
        applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
      end else begin
        applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0001);
      end
      if (k == 2 * WINDOW - 3) begin
        checkOutput("entog_early_valid", 32'(y_valid), 32'(0));
      end
    end
    checkOutput("entog_valid", 32'(y_valid), 32'(1));
    checkOutput("entog_y", 32'(y), 32'(pack4(16, 0, 0, 0)));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);

    // Reset mid-window discards the partial count and clears y
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
    end
    applyReset(1);
    checkOutput("midrst_y", 32'(y), 32'(0));
    checkOutput("midrst_valid", 32'(y_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
    end
    checkOutput("postrst_valid", 32'(y_valid), 32'(1));
    checkOutput("postrst_y", 32'(y), 32'(pack4(16, 0, 0, 0)));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);

    // start pulse while busy must not restart or lengthen the window
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus((k == 5), 1'b1, 4'b0001, 4'b0000);
      if (k == WINDOW - 2) begin
        checkOutput("restart_early_valid", 32'(y_valid), 32'(0));
        checkOutput("restart_early_busy", 32'(busy), 32'(1));
      end
    end
    checkOutput("restart_valid", 32'(y_valid), 32'(1));
    checkOutput("restart_y", 32'(y), 32'(pack4(16, 0, 0, 0)));
    checkOutput("restart_busy_end", 32'(busy), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
